decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
- Registered, flow-controlled instruction decode stage for the KGP-RISC pipeline; sits between the fetch unit and the ALU/branch/memory units.
- Splits each 32-bit instruction into opcode, rs, rt, imm1, imm2 and label.
- Sign- or zero-extends the immediates to a parametrised datapath width.
- Decouples fetch and execute with a valid/ready handshake and a 2-entry skid buffer. Supports flush on branch redirect, illegal-opcode flagging and a saturating count of decoded instructions.

Parameters:
XLEN, 32, width of imm1/imm2/label and PC outputs; legal range 26..64.
CNT_W, 16, width of decoded-instruction counter.
ILLEGAL_CHK, 1, 1 = flag opcodes outside the legal set; 0 = illegal always 0.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous; discard all buffered and output entries.
in_valid  in  1  instruction/PC offered by fetch.
in_ready  out  1  stage can accept this cycle.
in_instr  in  32  instruction word.
in_pc  in  XLEN  PC of instruction.
out_valid  out  1  decoded entry present.
out_ready  in  1  downstream accepts.
out_opcode  out  6  instr[31:26].
out_rs  out  5  instr[25:21].
out_rt  out  5  instr[20:16].
out_imm1  out  XLEN  16-bit immediate, extended.
out_imm2  out  XLEN  21-bit immediate, extended.
out_label  out  XLEN  instr[25:0] zero-extended.
out_pc  out  XLEN  PC of the decoded instruction.
out_illegal  out  1  opcode not in the legal set.
dec_count  out  CNT_W  number of output handshakes, saturating.

Behaviour:
- Extension rules, computed combinationally on the incoming word before capture:
  - imm1 is sign-extended from bit 15 for opcodes 001110 (lw) and 001111 (sw); zero-extended otherwise.
  - imm2 is sign-extended from bit 20 for opcodes 010000 (addi) and 010001 (comi); zero-extended otherwise.
  - label is always zero-extended.
  - The extension decision uses the opcode of the same word; there is no cross-entry mixing.
- Legal opcode set: 000000–000011, 001000–001111, 010000–010001, 100000–100111. Any other opcode with ILLEGAL_CHK=1 sets out_illegal=1 for that entry. The entry still flows normally; the stage never stalls on an illegal opcode.
- Storage is an output register (OR) plus one skid register (SK), each holding a valid bit and a full decoded record.
- in_ready = !SK.valid (registered, no combinational path from out_ready).
- out_valid = OR.valid. All out_* fields come from OR.
- Transfers: accept = in_valid & in_ready; drain = OR.valid & out_ready.
- Per-cycle update, in priority order:
  - flush=1: OR.valid=0, SK.valid=0; the input is not accepted that cycle even if in_valid=1. in_ready may read 1, but the accept is discarded. dec_count still increments if drain occurred that same cycle.
  - Otherwise:
    - If drain or !OR.valid: OR loads SK if SK.valid (SK clears, and any accept loads SK), else OR loads input if accept (else OR.valid=0 on drain).
    - If OR is held (OR.valid & !out_ready) and accept: SK loads input.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 instruction per cycle with out_ready held high.
- Ordering: strictly FIFO, no reordering and no loss.
- Full condition: OR.valid & SK.valid implies in_ready=0 on the next edge. in_instr/in_pc are ignored when in_ready=0.
- Output stability: while out_valid=1 and out_ready=0, every out_* field holds stable.
- dec_count increments by 1 on each drain and saturates at 2^CNT_W−1; it is not cleared by flush.
- Reset (rst_n=0, asynchronous):
  - OR.valid=0, SK.valid=0, in_ready=1 (after reset), dec_count=0.
  - All out_* data fields=0, out_illegal=0.
- Reset asserted mid-transfer drops all entries immediately; there is no partial output.

Test Plan:
1. lw x with in_instr=0x3822FFFC, out_ready=1 -> one cycle later out_opcode=001110, rs=1, rt=2, imm1=0xFFFFFFFC, imm2=0x0002FFFC (zero-ext, bit20=0), label=0x0022FFFC.
2. addi 0x4010_0000|0x1FFFFF (instr=0x401FFFFF) -> imm2=0xFFFFFFFF, imm1=0x0000FFFF; with XLEN=48 -> imm2=0xFFFFFFFFFFFF.
3. Backpressure: stream 4 instructions with out_ready=0 -> after 2 accepts in_ready=0; raise out_ready -> outputs appear in order I0..I3, no duplicates, dec_count=4.
4. Flush while OR and SK are full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the next accepted instruction emerges alone, with in_pc matching.
5. Opcode 111111 -> out_illegal=1, entry delivered; with ILLEGAL_CHK=0 -> out_illegal=0.
6. CNT_W=2, drain 5 instructions -> dec_count 1,2,3,3,3. Assert rst_n low asynchronously mid-stream -> out_valid=0 and dec_count=0 before the next clock edge.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: KGP-RISC decode stage; splits and extends instruction fields
// behind a valid/ready handshake with an output register plus one skid register.
module decode_stage_pipe #(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 16,
    parameter bit ILLEGAL_CHK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_opcode,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [XLEN-1:0]  out_imm1,
    output logic [XLEN-1:0]  out_imm2,
    output logic [XLEN-1:0]  out_label,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count
);
    typedef struct packed {
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [XLEN-1:0] imm1;
        logic [XLEN-1:0] imm2;
        logic [XLEN-1:0] label;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } rec_t;

    rec_t dec, or_q, sk_q;
    logic or_v, sk_v, accept, drain, sx1, sx2, legal;
    logic [5:0] op;

    assign op     = in_instr[31:26];
    assign sx1    = op == 6'b001110 || op == 6'b001111;
    assign sx2    = op == 6'b010000 || op == 6'b010001;
    assign legal  = op[5:2] == 4'b0000 || op[5:3] == 3'b001 || op[5:1] == 5'b01000 || op[5:3] == 3'b100;

    assign dec.opcode  = op;
    assign dec.rs      = in_instr[25:21];
    assign dec.rt      = in_instr[20:16];
    assign dec.imm1    = sx1 ? XLEN'($signed(in_instr[15:0])) : XLEN'(in_instr[15:0]);
    assign dec.imm2    = sx2 ? XLEN'($signed(in_instr[20:0])) : XLEN'(in_instr[20:0]);
    assign dec.label   = XLEN'(in_instr[25:0]);
    assign dec.pc      = in_pc;
    assign dec.illegal = ILLEGAL_CHK && !legal;

    assign in_ready = !sk_v;
    assign accept   = in_valid && !sk_v;
    assign drain    = or_v && out_ready;

    // Skid entry is always older than the input, so it refills OR first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_v      <= 1'b0;
            sk_v      <= 1'b0;
            or_q      <= '0;
            sk_q      <= '0;
            dec_count <= '0;
        end else begin
            if (drain && dec_count != '1)
                dec_count <= dec_count + CNT_W'(1);
            if (flush) begin
                or_v <= 1'b0;
                sk_v <= 1'b0;
            end else if (drain || !or_v) begin
                if (sk_v) begin
                    or_q <= sk_q;
                    or_v <= 1'b1;
                    sk_v <= accept;
                    if (accept)
                        sk_q <= dec;
                end else begin
                    or_v <= accept;
                    if (accept)
                        or_q <= dec;
                end
            end else if (accept) begin
                sk_q <= dec;
                sk_v <= 1'b1;
            end
        end
    end

    assign out_valid   = or_v;
    assign out_opcode  = or_q.opcode;
    assign out_rs      = or_q.rs;
    assign out_rt      = or_q.rt;
    assign out_imm1    = or_q.imm1;
    assign out_imm2    = or_q.imm2;
    assign out_label   = or_q.label;
    assign out_pc      = or_q.pc;
    assign out_illegal = or_q.illegal;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed vectors against a default instance and a
// 48-bit / 2-bit counter / no-illegal-check instance sharing the same stimulus.
module tb_decode_stage_pipe;
    logic clk = 1'b0;
    logic rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic in_ready, out_valid, out_illegal;
    logic [5:0] out_opcode;
    logic [4:0] out_rs, out_rt;
    logic [31:0] out_imm1, out_imm2, out_label, out_pc;
    logic [15:0] dec_count;
    logic in_ready_b, out_valid_b, out_illegal_b;
    logic [5:0] out_opcode_b;
    logic [4:0] out_rs_b, out_rt_b;
    logic [47:0] out_imm1_b, out_imm2_b, out_label_b, out_pc_b;
    logic [1:0] dec_count_b;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    decode_stage_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_imm1(out_imm1),
        .out_imm2(out_imm2), .out_label(out_label), .out_pc(out_pc),
        .out_illegal(out_illegal), .dec_count(dec_count)
    );

    decode_stage_pipe #(.XLEN(48), .CNT_W(2), .ILLEGAL_CHK(0)) u_alt (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .in_pc(48'(in_pc)), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_opcode(out_opcode_b), .out_rs(out_rs_b), .out_rt(out_rt_b), .out_imm1(out_imm1_b),
        .out_imm2(out_imm2_b), .out_label(out_label_b), .out_pc(out_pc_b),
        .out_illegal(out_illegal_b), .dec_count(dec_count_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] instr, input logic [31:0] pc);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_cnt", dec_count, 0);
        chk("rst_imm1", out_imm1, 0);
        chk("rst_ill", out_illegal, 0);
        rst_n = 1'b1;
        step();

        xfer(32'h3822FFFC, 32'h100);
        chk("lw_valid", out_valid, 1);
        chk("lw_op", out_opcode, 6'b001110);
        chk("lw_rs", out_rs, 1);
        chk("lw_rt", out_rt, 2);
        chk("lw_imm1", out_imm1, 32'hFFFFFFFC);
        chk("lw_imm2", out_imm2, 32'h0002FFFC);
        chk("lw_label", out_label, 32'h0022FFFC);
        chk("lw_pc", out_pc, 32'h100);
        chk("lw_imm1_48", out_imm1_b, 48'hFFFFFFFFFFFC);
        step();
        chk("lw_drained", out_valid, 0);
        chk("lw_cnt", dec_count, 1);

        xfer(32'h401FFFFF, 32'h104);
        chk("addi_imm2", out_imm2, 32'hFFFFFFFF);
        chk("addi_imm1", out_imm1, 32'h0000FFFF);
        chk("addi_imm2_48", out_imm2_b, 48'hFFFFFFFFFFFF);
        chk("addi_label_48", out_label_b, 48'h0000001FFFFF);
        step();

        xfer(32'hFC000000, 32'h400);
        chk("ill_valid", out_valid, 1);
        chk("ill_flag", out_illegal, 1);
        chk("ill_nochk", out_illegal_b, 0);
        step();
        xfer(32'h9C000000, 32'h404);
        chk("ill_100111", out_illegal, 0);
        step();
        xfer(32'h10000000, 32'h408);
        chk("ill_000100", out_illegal, 1);
        step();
        chk("ill_cnt", dec_count, 5);

        // Backpressure: I0..I3 at pc 0x200.. with out_ready low.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h20000000; in_pc = 32'h200; step();
        chk("bp_ready0", in_ready, 1);
        in_instr = 32'h24000000; in_pc = 32'h204; step();
        chk("bp_full", in_ready, 0);
        chk("bp_or_i0", out_pc, 32'h200);
        in_instr = 32'h28000000; in_pc = 32'h208; step();
        chk("bp_hold_pc", out_pc, 32'h200);
        chk("bp_hold_op", out_opcode, 6'b001000);
        out_ready = 1'b1; step();
        chk("bp_i1", out_pc, 32'h204);
        chk("bp_ready1", in_ready, 1);
        step();
        chk("bp_i2", out_pc, 32'h208);
        in_instr = 32'h2C000000; in_pc = 32'h20C; step();
        in_valid = 1'b0;
        chk("bp_i3", out_pc, 32'h20C);
        step();
        chk("bp_empty", out_valid, 0);
        chk("bp_cnt", dec_count, 9);

        // Flush with both registers full and input offered.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h04000000; in_pc = 32'h300; step();
        in_pc = 32'h304; step();
        chk("fl_full", in_ready, 0);
        in_pc = 32'h308; flush = 1'b1; step();
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        in_pc = 32'h30C; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_discard", out_valid, 0);
        xfer(32'h08000000, 32'h310);
        chk("fl_next_v", out_valid, 1);
        chk("fl_next_pc", out_pc, 32'h310);
        step();
        chk("fl_alone", out_valid, 0);
        chk("fl_cnt", dec_count, 10);
        xfer(32'h0C000000, 32'h500);
        flush = 1'b1; step();
        flush = 1'b0;
        chk("fl_drain_v", out_valid, 0);
        chk("fl_drain_cnt", dec_count, 11);

        // Counter saturation and asynchronous reset mid-stream.
        rst_n = 1'b0; #2;
        chk("sat_rst", dec_count_b, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_instr = 32'h00000000; in_pc = 32'h600 + 4 * i;
            step();
            chk("sat_cnt2", dec_count_b, (i > 3) ? 3 : i);
            chk("sat_cnt16", dec_count, i);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("ar_pre_v", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_cnt", dec_count, 0);
        chk("ar_cnt2", dec_count_b, 0);
        chk("ar_pc", out_pc, 0);
        #3 rst_n = 1'b1;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
